pll_reconf_sequencer: RTL and testbench

//  Upstream controller for the PLL mDRP interface. Watches a requested clock-mode input and issues the two

---
 rtl/pll_reconf_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_pll_reconf_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconf_sequencer.sv
// Sequences PLL mDRP reconfiguration: two wr strobes once lock is settled, then waits for relock.
// Optional retry-on-timeout behaviour is compiled in with `define PLL_RECONF_RETRY_EN.
module pll_reconf_sequencer #(
   parameter int unsigned MODE_W      = 2,
   parameter int unsigned LOCK_SETTLE = 16,
   parameter int unsigned WR_GAP      = 4,
   parameter int unsigned TIMEOUT     = 65535,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [MODE_W-1:0] mode_req,
   input  logic              pll_lock,
   output logic              wr,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [MODE_W-1:0] mode_cur
);

   localparam int unsigned LS_W  = $clog2(LOCK_SETTLE + 1);
   localparam int unsigned GAP_W = $clog2(WR_GAP + 1);
   localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR1,
      S_GAP,
      S_WR2,
      S_RELOCK
   } state_e;

   state_e            state_q, state_d;
   logic [MODE_W-1:0] sync1_q, sync2_q;
   logic [LS_W-1:0]   lock_cnt_q;
   logic              stable_q;
   logic [MODE_W-1:0] mode_tgt_q, mode_tgt_d;
   logic [MODE_W-1:0] mode_cur_q, mode_cur_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              wr_q, wr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              stable, pending, relocked;

`ifdef PLL_RECONF_RETRY_EN
   localparam int unsigned RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RT_W-1:0] retry_cnt_q, retry_cnt_d;
`else
   // MAX_RETRY only matters when retries are compiled in.
   logic unused_max_retry;
   assign unused_max_retry = ^MAX_RETRY;
`endif

   assign stable   = (lock_cnt_q == LS_W'(LOCK_SETTLE));
   assign pending  = (sync2_q != mode_cur_q);
   // Relock counts only when stability is newly reached, not carried over from before the strobes.
   assign relocked = stable & ~stable_q;

   // Mode synchroniser and lock-settle counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         lock_cnt_q <= '0;
         stable_q   <= 1'b0;
      end else begin
         sync1_q  <= mode_req;
         sync2_q  <= sync1_q;
         stable_q <= stable;
         if (!pll_lock)
            lock_cnt_q <= '0;
         else if (!stable)
            lock_cnt_q <= lock_cnt_q + LS_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mode_tgt_q  <= '0;
         mode_cur_q  <= '0;
         gap_cnt_q   <= '0;
         to_cnt_q    <= '0;
         wr_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef PLL_RECONF_RETRY_EN
         retry_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         mode_tgt_q  <= mode_tgt_d;
         mode_cur_q  <= mode_cur_d;
         gap_cnt_q   <= gap_cnt_d;
         to_cnt_q    <= to_cnt_d;
         wr_q        <= wr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
`ifdef PLL_RECONF_RETRY_EN
         retry_cnt_q <= retry_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      mode_tgt_d  = mode_tgt_q;
      mode_cur_d  = mode_cur_q;
      gap_cnt_d   = gap_cnt_q;
      to_cnt_d    = to_cnt_q;
      done_d      = 1'b0;
      err_d       = err_q;
`ifdef PLL_RECONF_RETRY_EN
      retry_cnt_d = retry_cnt_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (pending && stable) begin
               state_d    = S_WR1;
               mode_tgt_d = sync2_q;
            end
         end
         S_WR1: begin
            gap_cnt_d = '0;
            state_d   = pll_lock ? S_GAP : S_IDLE;
         end
         S_GAP: begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
            if (!pll_lock)
               state_d = S_IDLE;
            else if (gap_cnt_q == GAP_W'(WR_GAP - 1))
               state_d = S_WR2;
         end
         S_WR2: begin
            to_cnt_d = '0;
            state_d  = pll_lock ? S_RELOCK : S_IDLE;
         end
         S_RELOCK: begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (relocked) begin
               state_d     = S_IDLE;
               done_d      = 1'b1;
               mode_cur_d  = mode_tgt_q;
               err_d       = 1'b0;
`ifdef PLL_RECONF_RETRY_EN
               retry_cnt_d = '0;
`endif
            end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
               state_d = S_IDLE;
`ifdef PLL_RECONF_RETRY_EN
               // Leaving mode_cur alone keeps the request pending, so it restarts on next lock.
               if (retry_cnt_q < RT_W'(MAX_RETRY)) begin
                  retry_cnt_d = retry_cnt_q + RT_W'(1);
               end else begin
                  err_d       = 1'b1;
                  mode_cur_d  = mode_tgt_q;
                  retry_cnt_d = '0;
               end
`else
               err_d      = 1'b1;
               mode_cur_d = mode_tgt_q;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
      wr_d   = (state_d == S_WR1) || (state_d == S_WR2);
      busy_d = (state_d != S_IDLE);
   end

   assign wr       = wr_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign mode_cur = mode_cur_q;

endmodule

// File: tb/tb_pll_reconf_sequencer.sv
// Self-checking bench for pll_reconf_sequencer: timeline reference model plus directed and random stimulus.
module tb_pll_reconf_sequencer;

   localparam int unsigned MODE_W = 2;
   localparam int unsigned LS     = 16;
   localparam int unsigned GAP    = 4;
   localparam int unsigned TO     = 64;
   localparam int unsigned MR     = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              pll_lock;
   logic [MODE_W-1:0] mode_req;
   logic              wr, busy, done, err;
   logic [MODE_W-1:0] mode_cur;

   int n_checks = 0;
   int n_pass   = 0;
   bit started  = 1'b0;

   always #5 clk = ~clk;

   pll_reconf_sequencer #(
      .MODE_W(MODE_W), .LOCK_SETTLE(LS), .WR_GAP(GAP), .TIMEOUT(TO), .MAX_RETRY(MR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mode_req(mode_req), .pll_lock(pll_lock),
      .wr(wr), .busy(busy), .done(done), .err(err), .mode_cur(mode_cur)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
   endtask

   // Reference model: a sequence is described by its age in cycles since the start decision.
   int                lrun;
   bit                prev_stb;
   logic [MODE_W-1:0] hist0, hist1;
   bit                m_act, m_done, m_err;
   int                m_age;
   logic [MODE_W-1:0] m_tgt, m_cur;
`ifdef PLL_RECONF_RETRY_EN
   int                m_retry;
`endif

   always @(posedge clk or negedge rst_n) begin : model
      bit stb;
      bit rise;
      if (!rst_n) begin
         lrun = 0; prev_stb = 0; hist0 = '0; hist1 = '0;
         m_act = 0; m_done = 0; m_err = 0; m_age = 0; m_tgt = '0; m_cur = '0;
`ifdef PLL_RECONF_RETRY_EN
         m_retry = 0;
`endif
      end else begin
         stb    = (lrun == LS);
         rise   = stb && !prev_stb;
         m_done = 0;
         if (!m_act) begin
            if (hist1 != m_cur && stb) begin
               m_act = 1; m_age = 0; m_tgt = hist1;
            end
         end else if (m_age <= int'(GAP) + 1) begin
            if (!pll_lock) m_act = 0;
            else m_age++;
         end else if (rise) begin
            m_act = 0; m_done = 1; m_cur = m_tgt; m_err = 0;
`ifdef PLL_RECONF_RETRY_EN
            m_retry = 0;
`endif
         end else if (m_age - (int'(GAP) + 2) == int'(TO) - 1) begin
            m_act = 0;
`ifdef PLL_RECONF_RETRY_EN
            if (m_retry < int'(MR)) m_retry++;
            else begin m_err = 1; m_cur = m_tgt; m_retry = 0; end
`else
            m_err = 1; m_cur = m_tgt;
`endif
         end else begin
            m_age++;
         end
         prev_stb = stb;
         lrun  = pll_lock ? ((lrun < int'(LS)) ? lrun + 1 : lrun) : 0;
         hist1 = hist0;
         hist0 = mode_req;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("wr", int'(wr), int'(m_act && (m_age == 0 || m_age == int'(GAP) + 1)));
         chk("busy", int'(busy), int'(m_act));
         chk("done", int'(done), int'(m_done));
         chk("err", int'(err), int'(m_err));
         chk("mode_cur", int'(mode_cur), int'(m_cur));
      end
   end

   // sel: 0=wr, 1=done, 2=err; returns the number of falling edges waited, -1 if the bound expired
   task automatic wait_sig(input int sel, input int limit, input string nm, output int n);
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         if ((sel == 0 && wr) || (sel == 1 && done) || (sel == 2 && err)) break;
         if (n >= limit) begin
            chk({nm, "_bound"}, 0, 1);
            n = -1;
            break;
         end
      end
   endtask

   task automatic relock(input int drop);
      @(negedge clk);
      pll_lock = 1'b0;
      repeat (drop) @(negedge clk);
      pll_lock = 1'b1;
   endtask

   initial begin
      int n;
      int cnt;
      int len;
      rst_n = 1'b0; pll_lock = 1'b0; mode_req = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1; started = 1'b1;
      chk("rst_wr", int'(wr), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_mode_cur", int'(mode_cur), 0);

      // No request pending: nothing happens
      pll_lock = 1'b1; cnt = 0;
      repeat (40) begin @(negedge clk); if (wr || busy) cnt++; end
      chk("t1_idle_activity", cnt, 0);

      // Basic two-strobe sequence with relock
      mode_req = 2'd2;
      wait_sig(0, 50, "t2_wr1", n);  chk("t2_wr1_lat", n, 3);
      wait_sig(0, 20, "t2_wr2", n);  chk("t2_wr_gap", n, int'(GAP) + 1);
      relock(5);
      wait_sig(1, 60, "t2_done", n); chk("t2_done_lat", n, int'(LS) + 1);
      chk("t2_mode_cur", int'(mode_cur), 2);
      chk("t2_busy", int'(busy), 0);
      @(negedge clk); chk("t2_done_pulse", int'(done), 0);

      // Lock lost during the gap aborts, then the full sequence repeats
      mode_req = 2'd1;
      wait_sig(0, 50, "t3_wr1", n);  chk("t3_wr1_lat", n, 3);
      repeat (2) @(negedge clk);
      pll_lock = 1'b0; cnt = 0;
      repeat (10) begin @(negedge clk); if (wr || done) cnt++; end
      chk("t3_abort_quiet", cnt, 0);
      chk("t3_abort_mode", int'(mode_cur), 2);
      pll_lock = 1'b1;
      wait_sig(0, 60, "t3_rewr1", n); chk("t3_rewr1_lat", n, int'(LS) + 1);
      wait_sig(0, 20, "t3_rewr2", n); chk("t3_rewr_gap", n, int'(GAP) + 1);
      relock(3);
      wait_sig(1, 60, "t3_done", n);  chk("t3_done_lat", n, int'(LS) + 1);
      chk("t3_mode_cur", int'(mode_cur), 1);

      // Relock timeout
      mode_req = 2'd3;
`ifdef PLL_RECONF_RETRY_EN
      cnt = 0;
      repeat (MR + 1) begin
         wait_sig(0, 60, "t5_wr1", n);
         wait_sig(0, 20, "t5_wr2", n);
         if (n == int'(GAP) + 1) cnt++;
         @(negedge clk); pll_lock = 1'b0;
         n = 0;
         while (busy && n < 200) begin @(negedge clk); n++; end
         pll_lock = 1'b1;
      end
      chk("t5_strobe_pairs", cnt, int'(MR) + 1);
`else
      wait_sig(0, 50, "t4_wr1", n);
      wait_sig(0, 20, "t4_wr2", n);
      @(negedge clk); pll_lock = 1'b0;
      wait_sig(2, 200, "t4_err", n); chk("t4_err_lat", n, int'(TO));
      chk("t4_busy", int'(busy), 0);
      pll_lock = 1'b1;
`endif
      repeat (20) @(negedge clk);
      chk("t4_err_sticky", int'(err), 1);
      chk("t4_mode_cur", int'(mode_cur), 3);

      // Request changes mid-sequence; then success clears err
      mode_req = 2'd1;
      wait_sig(0, 50, "t6_wr1", n);  chk("t6_wr1_lat", n, 3);
      repeat (2) @(negedge clk);
      mode_req = 2'd3;
      wait_sig(0, 20, "t6_wr2", n);
      relock(3);
      wait_sig(1, 60, "t6_done1", n);
      chk("t6_mode_cur1", int'(mode_cur), 1);
      chk("t6_err_clear", int'(err), 0);
      wait_sig(0, 20, "t6_wr1b", n); chk("t6_restart_lat", n, 1);
      wait_sig(0, 20, "t6_wr2b", n);
      relock(3);
      wait_sig(1, 60, "t6_done2", n);
      chk("t6_mode_cur2", int'(mode_cur), 3);

      // Asynchronous reset mid-sequence
      mode_req = 2'd0;
      wait_sig(0, 50, "rst_seq_wr", n);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_wr", int'(wr), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_mode_cur", int'(mode_cur), 0);
      @(negedge clk); rst_n = 1'b1;

      // Random lock behaviour and mode requests
      repeat (300) begin
         pll_lock = ($urandom_range(0, 3) != 0);
         len = pll_lock ? int'($urandom_range(1, 80)) : int'($urandom_range(1, 20));
         if ($urandom_range(0, 2) == 0) mode_req = MODE_W'($urandom);
         repeat (len) begin
            @(negedge clk);
            if ($urandom_range(0, 40) == 0) mode_req = MODE_W'($urandom);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
